// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_responder
//  Purpose  : SPI flash target (mode 0, single-bit, MSB first) running on the
//             system clock. SCK/CS_N/MOSI are oversampled. READ (and
//             optionally FAST READ) commands are answered from an internal
//             byte array that is preloaded through a simple write port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: SPI_FLASH_RESPONDER_FAST_READ_EN
//    defined   -> CMD_FAST is decoded and the 8-clock DUMMY phase is built
//    undefined -> CMD_FAST is an unsupported opcode (IGNORE + err_o pulse)
// ----------------------------------------------------------------------------
//  Ports
//    wb_clk_i       in   1   system clock, rising edge
//    wb_rst_i       in   1   asynchronous active-high reset
//    spi_clk_i      in   1   SCK from master (asynchronous)
//    spi_cs_n_i     in   1   chip select, active low (asynchronous)
//    spi_mosi_i     in   1   serial data from master
//    spi_miso_o     out  1   serial data to master
//    spi_miso_oe_o  out  1   MISO output enable
//    ld_we_i        in   1   preload write strobe
//    ld_adr_i       in   AW  preload byte address
//    ld_dat_i       in   8   preload data
//    busy_o         out  1   transaction in progress
//    cmd_o          out  8   last received opcode
//    err_o          out  1   one-cycle pulse on unsupported opcode
//  Requirement on the master: f(wb_clk_i) >= 8 x f(SCK).
// ============================================================================
module spi_flash_responder #(
  parameter int          AW       = 12,
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter logic [7:0]  CMD_FAST = 8'h0B
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          spi_clk_i,
  input  logic          spi_cs_n_i,
  input  logic          spi_mosi_i,
  output logic          spi_miso_o,
  output logic          spi_miso_oe_o,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_adr_i,
  input  logic [7:0]    ld_dat_i,
  output logic          busy_o,
  output logic [7:0]    cmd_o,
  output logic          err_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] DUMMY  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] IGNORE = 3'd5;

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam logic FAST_EN = 1'b1;
`else
  localparam logic FAST_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;

  // The CS chain resets to 0 (as if asserted): if the master still holds
  // cs_n low when reset releases, no falling edge is seen and the block
  // stays in IDLE until cs_n goes high and falls again.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_d    <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= spi_clk_i;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      cs_s1   <= spi_cs_n_i;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= spi_mosi_i;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_fall  = ~cs_s2 & cs_d;
  assign cs_rise  = cs_s2 & ~cs_d;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]    state;
  logic [4:0]    bit_cnt;
  logic [6:0]    cmd_sh;     // first seven opcode bits; the eighth is live MOSI
  logic [AW-1:0] addr;
  logic [7:0]    out_sh;
  logic          load_next;  // next fall loads a freshly fetched byte
  logic          fast_txn;
  logic [7:0]    rd_data;

  logic [7:0]    cmd_next;
  logic [AW-1:0] addr_shift;
  logic [AW-1:0] addr_inc;
  logic          is_read, is_fast, supported;

  assign cmd_next   = {cmd_sh, mosi_s2};
  // Shifting left through an AW-bit register keeps only the low AW bits of
  // the 24-bit address; the upper bits fall off the top.
  assign addr_shift = {addr[AW-2:0], mosi_s2};
  assign addr_inc   = addr + {{(AW-1){1'b0}}, 1'b1};
  assign is_read    = (cmd_next == CMD_READ);
  assign is_fast    = FAST_EN && (cmd_next == CMD_FAST);
  assign supported  = is_read | is_fast;

  assign busy_o = (state != IDLE);

  // --------------------------------------------------------------------------
  // Fetch request: issued on the rise that completes the address (READ),
  // the dummy byte (FAST), or the last bit of each data byte.
  // --------------------------------------------------------------------------
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;

  always_comb begin
    fetch_en   = 1'b0;
    fetch_addr = addr;
    if (sck_rise && !cs_rise) begin
      case (state)
        ADDR: begin
          if (bit_cnt == 5'd23 && !fast_txn) begin
            fetch_en   = 1'b1;
            fetch_addr = addr_shift;
          end
        end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        DUMMY: begin
          if (bit_cnt == 5'd7) begin
            fetch_en   = 1'b1;
            fetch_addr = addr;
          end
        end
`endif
        DATA: begin
          if (bit_cnt == 5'd7) begin
            fetch_en   = 1'b1;
            fetch_addr = addr_inc;
          end
        end
        default: begin
          fetch_en = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Byte array: preload write port plus registered read. A read and a write
  // to the same address in one cycle returns the old contents. Not reset.
  // --------------------------------------------------------------------------
  logic [7:0] mem [0:(2**AW)-1];

  always_ff @(posedge wb_clk_i) begin
    if (ld_we_i) begin
      mem[ld_adr_i] <= ld_dat_i;
    end
    if (fetch_en) begin
      rd_data <= mem[fetch_addr];
    end
  end

  // --------------------------------------------------------------------------
  // FAST READ transaction flag
  // --------------------------------------------------------------------------
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fast_txn <= 1'b0;
    end else if (state == CMD && sck_rise && bit_cnt == 5'd7 && !cs_rise) begin
      fast_txn <= is_fast;
    end
  end
`else
  assign fast_txn = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Main FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      bit_cnt       <= 5'd0;
      cmd_sh        <= 7'd0;
      addr          <= '0;
      out_sh        <= 8'd0;
      load_next     <= 1'b0;
      cmd_o         <= 8'h00;
      err_o         <= 1'b0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (cs_rise) begin
        // Deselect aborts whatever is in flight, partial bytes included.
        state         <= IDLE;
        bit_cnt       <= 5'd0;
        load_next     <= 1'b0;
        spi_miso_o    <= 1'b0;
        spi_miso_oe_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= 5'd0;
            end
          end

          CMD: begin
            if (sck_rise) begin
              cmd_sh <= cmd_next[6:0];
              if (bit_cnt == 5'd7) begin
                cmd_o   <= cmd_next;
                bit_cnt <= 5'd0;
                if (supported) begin
                  state <= ADDR;
                end else begin
                  state <= IGNORE;
                  err_o <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          ADDR: begin
            if (sck_rise) begin
              addr <= addr_shift;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= 5'd0;
                if (fast_txn) begin
                  state <= DUMMY;
                end else begin
                  state     <= DATA;
                  load_next <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
          DUMMY: begin
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt   <= 5'd0;
                state     <= DATA;
                load_next <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`endif

          DATA: begin
            if (sck_rise) begin
              if (bit_cnt == 5'd7) begin
                // Last bit of this byte: the next byte was fetched this cycle.
                bit_cnt   <= 5'd0;
                addr      <= addr_inc;
                load_next <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
            if (sck_fall) begin
              spi_miso_oe_o <= 1'b1;
              if (load_next) begin
                spi_miso_o <= rd_data[7];
                out_sh     <= {rd_data[6:0], 1'b0};
                load_next  <= 1'b0;
              end else begin
                spi_miso_o <= out_sh[7];
                out_sh     <= {out_sh[6:0], 1'b0};
              end
            end
          end

          IGNORE: begin
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
          end

          default: begin
            state         <= IDLE;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_spi_flash_responder
//  Purpose  : Self-checking bench for spi_flash_responder. A byte-array model
//             of the flash contents supplies expected read data; directed
//             scenarios cover reset, wrap, bad opcode, abort, mid-transaction
//             reset and FAST READ, followed by randomized reads.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int AW = 12;
  localparam int DEPTH = 4096;

  logic          wb_clk_i;
  logic          wb_rst_i;
  logic          spi_clk_i;
  logic          spi_cs_n_i;
  logic          spi_mosi_i;
  logic          spi_miso_o;
  logic          spi_miso_oe_o;
  logic          ld_we_i;
  logic [AW-1:0] ld_adr_i;
  logic [7:0]    ld_dat_i;
  logic          busy_o;
  logic [7:0]    cmd_o;
  logic          err_o;

  spi_flash_responder #(.AW(AW)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .spi_clk_i     (spi_clk_i),
    .spi_cs_n_i    (spi_cs_n_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .ld_we_i       (ld_we_i),
    .ld_adr_i      (ld_adr_i),
    .ld_dat_i      (ld_dat_i),
    .busy_o        (busy_o),
    .cmd_o         (cmd_o),
    .err_o         (err_o)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks   = 0;
  int n_errors   = 0;
  int err_pulses = 0;
  int half_ns    = 60;
  logic [7:0] model_mem [0:DEPTH-1];

  // err_o is a single-cycle pulse; counting high samples counts pulses.
  always @(negedge wb_clk_i) begin
    if (err_o === 1'b1) err_pulses++;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input logic [7:0] d);
    @(negedge wb_clk_i);
    ld_we_i  = 1'b1;
    ld_adr_i = AW'(a);
    ld_dat_i = d;
    @(negedge wb_clk_i);
    ld_we_i  = 1'b0;
    model_mem[a % DEPTH] = d;
  endtask

  // Mode 0: MOSI set while SCK low, MISO sampled just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = 8'h00;
    oe_all = 1'b1;
    oe_any = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi_i = tx[i];
      #(half_ns);
      rx     = {rx[6:0], spi_miso_o};
      oe_all = oe_all & spi_miso_oe_o;
      oe_any = oe_any | spi_miso_oe_o;
      spi_clk_i = 1'b1;
      #(half_ns);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    spi_bits(tx, 8, rx, oe_all, oe_any);
  endtask

  task automatic cs_begin();
    spi_clk_i  = 1'b0;
    spi_cs_n_i = 1'b0;
    #100;
  endtask

  task automatic cs_end_plain();
    #(half_ns);
    spi_cs_n_i = 1'b1;
    #100;
  endtask

  // Deselect aligned to the clock: busy must still be high two edges later
  // and low on the third.
  task automatic cs_end_timed(input string tag);
    #(half_ns);
    @(negedge wb_clk_i);
    spi_cs_n_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1;
    check_value({tag, "_busy_hold"}, 32'(busy_o), 32'd1);
    @(posedge wb_clk_i);
    #1;
    check_value({tag, "_busy_drop"}, 32'(busy_o), 32'd0);
    check_value({tag, "_oe_off"}, 32'(spi_miso_oe_o), 32'd0);
    check_value({tag, "_miso_off"}, 32'(spi_miso_o), 32'd0);
    #100;
  endtask

  task automatic send_header(input logic [7:0] op, input logic [23:0] a24, output logic any_oe);
    logic [7:0] rx;
    logic all_o, any_o;
    any_oe = 1'b0;
    spi_byte(op, rx, all_o, any_o);          any_oe |= any_o;
    spi_byte(a24[23:16], rx, all_o, any_o);  any_oe |= any_o;
    spi_byte(a24[15:8], rx, all_o, any_o);   any_oe |= any_o;
    spi_byte(a24[7:0], rx, all_o, any_o);    any_oe |= any_o;
  endtask

  task automatic do_read(input logic [23:0] a24, input int nbytes, input string tag);
    logic [7:0] rx;
    logic all_o, any_o, pre_oe;
    int base;
    base = int'(a24[AW-1:0]);
    cs_begin();
    send_header(8'h03, a24, pre_oe);
    check_value({tag, "_busy_mid"}, 32'(busy_o), 32'd1);
    check_value({tag, "_oe_hdr"}, 32'(pre_oe), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(8'($urandom), rx, all_o, any_o);
      check_value($sformatf("%s_byte%0d", tag, i), 32'(rx), 32'(model_mem[(base + i) % DEPTH]));
      check_value($sformatf("%s_oe_byte%0d", tag, i), 32'(all_o), 32'd1);
    end
    cs_end_timed(tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rx;
    logic all_o, any_o, acc_oe;
    int err0;

    wb_rst_i   = 1'b1;
    spi_clk_i  = 1'b0;
    spi_cs_n_i = 1'b1;
    spi_mosi_i = 1'b0;
    ld_we_i    = 1'b0;
    ld_adr_i   = '0;
    ld_dat_i   = 8'h00;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;

    // ---------------- reset state ----------------
    repeat (4) @(posedge wb_clk_i);
    #1;
    check_value("rst_miso", 32'(spi_miso_o), 32'd0);
    check_value("rst_oe", 32'(spi_miso_oe_o), 32'd0);
    check_value("rst_busy", 32'(busy_o), 32'd0);
    check_value("rst_cmd", 32'(cmd_o), 32'd0);
    check_value("rst_err", 32'(err_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #100;

    // ---------------- basic 4-byte read ----------------
    preload(12'h010, 8'hA5);
    preload(12'h011, 8'h3C);
    preload(12'h012, 8'h00);
    preload(12'h013, 8'hFF);
    do_read(24'h000010, 4, "read4");
    check_value("read4_cmd", 32'(cmd_o), 32'h03);

    // ---------------- address wrap ----------------
    preload(12'hFFF, 8'h11);
    preload(12'h000, 8'h22);
    do_read(24'h000FFF, 2, "wrap");

    // ---------------- unsupported opcode ----------------
    err0 = err_pulses;
    cs_begin();
    spi_byte(8'h9F, rx, all_o, any_o);
    acc_oe = any_o;
    #50;
    check_value("bad_cmd", 32'(cmd_o), 32'h9F);
    spi_byte(8'($urandom), rx, all_o, any_o);  acc_oe |= any_o;
    spi_byte(8'($urandom), rx, all_o, any_o);  acc_oe |= any_o;
    check_value("bad_oe", 32'(acc_oe), 32'd0);
    cs_end_timed("bad");
    check_value("bad_err_cnt", 32'(err_pulses - err0), 32'd1);
    do_read(24'h000010, 2, "after_bad");

    // ---------------- abort mid data byte ----------------
    cs_begin();
    send_header(8'h03, 24'h000010, acc_oe);
    spi_bits(8'h00, 3, rx, all_o, any_o);
    check_value("abort_bits", 32'(rx), 32'h05);
    check_value("abort_oe_on", 32'(all_o), 32'd1);
    #(half_ns);
    @(negedge wb_clk_i);
    spi_cs_n_i = 1'b1;
    repeat (4) @(posedge wb_clk_i);
    #1;
    check_value("abort_oe_off", 32'(spi_miso_oe_o), 32'd0);
    check_value("abort_busy", 32'(busy_o), 32'd0);
    #100;
    do_read(24'h000010, 1, "after_abort");

    // ---------------- reset mid address, cs held low ----------------
    cs_begin();
    spi_byte(8'h03, rx, all_o, any_o);
    spi_byte(8'h00, rx, all_o, any_o);
    spi_bits(8'h00, 3, rx, all_o, any_o);
    #13;
    wb_rst_i = 1'b1;
    #1;
    check_value("mrst_miso", 32'(spi_miso_o), 32'd0);
    check_value("mrst_oe", 32'(spi_miso_oe_o), 32'd0);
    check_value("mrst_busy", 32'(busy_o), 32'd0);
    check_value("mrst_cmd", 32'(cmd_o), 32'd0);
    check_value("mrst_err", 32'(err_o), 32'd0);
    #30;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    acc_oe = 1'b0;
    spi_byte(8'h03, rx, all_o, any_o);  acc_oe |= any_o;
    spi_byte(8'h00, rx, all_o, any_o);  acc_oe |= any_o;
    check_value("mrst_no_drive", 32'(acc_oe), 32'd0);
    check_value("mrst_idle_busy", 32'(busy_o), 32'd0);
    check_value("mrst_idle_cmd", 32'(cmd_o), 32'd0);
    cs_end_plain();
    do_read(24'h000011, 1, "after_rst");

    // ---------------- FAST READ ----------------
    err0 = err_pulses;
    cs_begin();
    send_header(8'h0B, 24'h000010, acc_oe);
    spi_byte(8'h00, rx, all_o, any_o);  acc_oe |= any_o;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    check_value("fast_oe_pre", 32'(acc_oe), 32'd0);
    spi_byte(8'h00, rx, all_o, any_o);
    check_value("fast_data", 32'(rx), 32'(model_mem[12'h010]));
    check_value("fast_oe_data", 32'(all_o), 32'd1);
    cs_end_timed("fast");
    check_value("fast_err_cnt", 32'(err_pulses - err0), 32'd0);
`else
    spi_byte(8'h00, rx, all_o, any_o);  acc_oe |= any_o;
    check_value("fast_off_oe", 32'(acc_oe), 32'd0);
    check_value("fast_off_cmd", 32'(cmd_o), 32'h0B);
    cs_end_timed("fast_off");
    check_value("fast_off_err_cnt", 32'(err_pulses - err0), 32'd1);
`endif

    // ---------------- randomized reads ----------------
    for (int t = 0; t < 12; t++) begin
      int start, len;
      logic [23:0] a24;
      half_ns = $urandom_range(45, 80);
      start   = $urandom_range(0, DEPTH - 1);
      len     = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) preload((start + k) % DEPTH, 8'($urandom));
      a24 = {12'($urandom), 12'(start)};
      do_read(a24, len, $sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
